// File: rtl/jtexterm_pkg.sv
// Shared widths, region start defaults, bank encodings and the SDRAM request payload
// for the ROM download path.
package jtexterm_pkg;

   localparam int unsigned IOCTL_AW = 25;
   localparam int unsigned PROG_AW  = 22;
   localparam int unsigned PROG_DW  = 16;
   localparam int unsigned PROM_AW  = 8;
   localparam int unsigned PROM_DW  = 4;
   localparam int unsigned PROM_SIZE = 256;

   localparam logic [IOCTL_AW-1:0] BA1_START_DEF  = 25'h20000;
   localparam logic [IOCTL_AW-1:0] BA2_START_DEF  = 25'h30000;
   localparam logic [IOCTL_AW-1:0] BA3_START_DEF  = 25'h130000;
   localparam logic [IOCTL_AW-1:0] PROM_START_DEF = 25'h140000;

   typedef enum logic [1:0] {
      BANK0 = 2'd0,
      BANK1 = 2'd1,
      BANK2 = 2'd2,
      BANK3 = 2'd3
   } bank_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_e;

   typedef struct packed {
      logic [PROG_AW-1:0] addr;
      logic [PROG_DW-1:0] data;
      logic [1:0]         mask;
      bank_e              ba;
   } prog_req_t;

   // Active-high lane mask: an even byte goes to the low lane, so the upper lane is masked
   function automatic logic [1:0] lane_mask(input logic odd);
      return odd ? 2'b01 : 2'b10;
   endfunction

endpackage

// File: rtl/jtexterm_dwn_dec.sv
// Combinational region decoder: maps an ioctl byte address to SDRAM bank + offset,
// the colour PROM, or nothing.
module jtexterm_dwn_dec
   import jtexterm_pkg::*;
#(
   parameter logic [IOCTL_AW-1:0] BA1_START  = BA1_START_DEF,
   parameter logic [IOCTL_AW-1:0] BA2_START  = BA2_START_DEF,
   parameter logic [IOCTL_AW-1:0] BA3_START  = BA3_START_DEF,
   parameter logic [IOCTL_AW-1:0] PROM_START = PROM_START_DEF
)(
   input  logic [IOCTL_AW-1:0] addr,
   output logic [1:0]          bank_c,
   output logic [IOCTL_AW-1:0] off_c,
   output logic                is_prom_c,
   output logic                drop_c
);

   localparam logic [IOCTL_AW-1:0] PROM_END = PROM_START + IOCTL_AW'(PROM_SIZE);

   // Ordered unsigned compares: first region whose upper bound exceeds the address wins
   always_comb begin
      bank_c    = BANK0;
      off_c     = addr;
      is_prom_c = 1'b0;
      drop_c    = 1'b0;
      if (addr < BA1_START) begin
         bank_c = BANK0;
         off_c  = addr;
      end else if (addr < BA2_START) begin
         bank_c = BANK1;
         off_c  = addr - BA1_START;
      end else if (addr < BA3_START) begin
         bank_c = BANK2;
         off_c  = addr - BA2_START;
      end else if (addr < PROM_START) begin
         bank_c = BANK3;
         off_c  = addr - BA3_START;
      end else if (addr < PROM_END) begin
         is_prom_c = 1'b1;
         off_c     = addr - PROM_START;
      end else begin
         drop_c = 1'b1;
      end
   end

endmodule

// File: rtl/jtexterm_prom_we.sv
// ROM download write engine: turns ioctl byte strobes into SDRAM byte-lane writes
// (with a one-entry overflow buffer) and colour PROM write pulses.
module jtexterm_prom_we
   import jtexterm_pkg::*;
#(
   parameter logic [IOCTL_AW-1:0] BA1_START  = BA1_START_DEF,
   parameter logic [IOCTL_AW-1:0] BA2_START  = BA2_START_DEF,
   parameter logic [IOCTL_AW-1:0] BA3_START  = BA3_START_DEF,
   parameter logic [IOCTL_AW-1:0] PROM_START = PROM_START_DEF
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                downloading,
   input  logic [IOCTL_AW-1:0] ioctl_addr,
   input  logic [7:0]          ioctl_dout,
   input  logic                ioctl_wr,
   output logic [PROG_AW-1:0]  prog_addr,
   output logic [PROG_DW-1:0]  prog_data,
   output logic [1:0]          prog_mask,
   output logic [1:0]          prog_ba,
   output logic                prog_we,
   output logic                prog_rd,
   input  logic                prog_ack,
   input  logic                prog_rdy,
   output logic                prom_we,
   output logic [PROM_AW-1:0]  prom_addr,
   output logic [PROM_DW-1:0]  prom_data,
   output logic                dwnld_busy,
   output logic                ovf
);

   logic [1:0]          dec_bank;
   logic [IOCTL_AW-1:0] dec_off;
   logic                dec_prom, dec_drop;

   jtexterm_dwn_dec #(
      .BA1_START  (BA1_START),
      .BA2_START  (BA2_START),
      .BA3_START  (BA3_START),
      .PROM_START (PROM_START)
   ) u_dec (
      .addr      (ioctl_addr),
      .bank_c    (dec_bank),
      .off_c     (dec_off),
      .is_prom_c (dec_prom),
      .drop_c    (dec_drop)
   );

   state_e              state_q, state_nx;
   prog_req_t           req_q, req_nx, buf_q, buf_nx, new_req;
   logic                buf_vld_q, buf_vld_nx;
   logic                we_q, we_nx, ovf_q, ovf_nx, busy_q, busy_nx;
   logic                prom_we_q, prom_we_nx;
   logic [PROM_AW-1:0]  prom_addr_q, prom_addr_nx;
   logic [PROM_DW-1:0]  prom_data_q, prom_data_nx;
   logic                acc, sdram_acc, prom_acc;

   // Write completion is defined by prog_ack alone; the upper offset bits exceed the SDRAM span
   logic unused_sig;
   assign unused_sig = ^{prog_rdy, dec_off[IOCTL_AW-1:PROG_AW+1]};

   assign acc       = ioctl_wr & downloading;
   assign sdram_acc = acc & ~dec_drop & ~dec_prom;
   assign prom_acc  = acc & dec_prom;

   always_comb begin
      new_req.addr = dec_off[PROG_AW:1];
      new_req.data = {ioctl_dout, ioctl_dout};
      new_req.mask = lane_mask(dec_off[0]);
      new_req.ba   = bank_e'(dec_bank);
   end

   // Next-state: request sequencing, buffering, PROM pulse and status flags
   always_comb begin
      state_nx     = state_q;
      req_nx       = req_q;
      buf_nx       = buf_q;
      buf_vld_nx   = buf_vld_q;
      we_nx        = 1'b0;
      ovf_nx       = ovf_q;
      prom_we_nx   = 1'b0;
      prom_addr_nx = prom_addr_q;
      prom_data_nx = prom_data_q;
      busy_nx      = downloading | (state_q == ST_WRITE) | buf_vld_q;

      if (prom_acc) begin
         prom_we_nx   = 1'b1;
         prom_addr_nx = dec_off[PROM_AW-1:0];
         prom_data_nx = ioctl_dout[PROM_DW-1:0];
      end

      case (state_q)
         ST_IDLE: begin
            if (sdram_acc) begin
               state_nx = ST_WRITE;
               req_nx   = new_req;
               we_nx    = 1'b1;
            end
         end
         ST_WRITE: begin
            if (we_q && prog_ack) begin
               // Next request is loaded with prog_we low for one cycle before it rises
               if (buf_vld_q) begin
                  req_nx     = buf_q;
                  buf_vld_nx = sdram_acc;
                  if (sdram_acc) buf_nx = new_req;
               end else if (sdram_acc) begin
                  req_nx = new_req;
               end else begin
                  state_nx = ST_IDLE;
               end
            end else begin
               we_nx = 1'b1;
               if (sdram_acc) begin
                  if (buf_vld_q) begin
                     ovf_nx = 1'b1;
                  end else begin
                     buf_nx     = new_req;
                     buf_vld_nx = 1'b1;
                  end
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         req_q       <= '{addr: '0, data: '0, mask: 2'b11, ba: BANK0};
         buf_q       <= '{addr: '0, data: '0, mask: 2'b11, ba: BANK0};
         buf_vld_q   <= 1'b0;
         we_q        <= 1'b0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
         prom_we_q   <= 1'b0;
         prom_addr_q <= '0;
         prom_data_q <= '0;
      end else begin
         state_q     <= state_nx;
         req_q       <= req_nx;
         buf_q       <= buf_nx;
         buf_vld_q   <= buf_vld_nx;
         we_q        <= we_nx;
         ovf_q       <= ovf_nx;
         busy_q      <= busy_nx;
         prom_we_q   <= prom_we_nx;
         prom_addr_q <= prom_addr_nx;
         prom_data_q <= prom_data_nx;
      end
   end

   assign prog_addr  = req_q.addr;
   assign prog_data  = req_q.data;
   assign prog_mask  = req_q.mask;
   assign prog_ba    = req_q.ba;
   assign prog_we    = we_q;
   assign prog_rd    = 1'b0;
   assign prom_we    = prom_we_q;
   assign prom_addr  = prom_addr_q;
   assign prom_data  = prom_data_q;
   assign dwnld_busy = busy_q;
   assign ovf        = ovf_q;

endmodule

// File: tb/tb_jtexterm_prom_we.sv
// Directed bench for jtexterm_prom_we: region decode, PROM pulses, buffering/overflow,
// simultaneous ack+strobe, reset mid-write and busy tail after download end.
module tb_jtexterm_prom_we;

   logic        clk = 1'b0;
   logic        rst, downloading, ioctl_wr, prog_ack, prog_rdy;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [21:0] prog_addr;
   logic [15:0] prog_data;
   logic [1:0]  prog_mask, prog_ba;
   logic        prog_we, prog_rd, prom_we, dwnld_busy, ovf;
   logic [7:0]  prom_addr;
   logic [3:0]  prom_data;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   jtexterm_prom_we dut (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .ioctl_addr  (ioctl_addr),
      .ioctl_dout  (ioctl_dout),
      .ioctl_wr    (ioctl_wr),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .prog_mask   (prog_mask),
      .prog_ba     (prog_ba),
      .prog_we     (prog_we),
      .prog_rd     (prog_rd),
      .prog_ack    (prog_ack),
      .prog_rdy    (prog_rdy),
      .prom_we     (prom_we),
      .prom_addr   (prom_addr),
      .prom_data   (prom_data),
      .dwnld_busy  (dwnld_busy),
      .ovf         (ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle byte strobe; returns 1 time unit after the edge that sampled it
   task automatic strobe(input logic [24:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(posedge clk); #1;
      ioctl_wr   = 1'b0;
   endtask

   task automatic ack;
      @(posedge clk); #1;
      prog_ack = 1'b1;
      @(posedge clk); #1;
      prog_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; prog_ack = 1'b0; prog_rdy = 1'b0;
      ioctl_addr = '0; ioctl_dout = '0;
      tick(3);
      rst = 1'b0;
      check("rst_we", 32'(prog_we), 32'd0);
      check("rst_prom_we", 32'(prom_we), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_busy", 32'(dwnld_busy), 32'd0);
      check("rst_mask", 32'(prog_mask), 32'd3);
      check("rst_addr", 32'(prog_addr), 32'd0);
      check("rst_rd", 32'(prog_rd), 32'd0);

      // Bank 0, odd byte
      downloading = 1'b1;
      strobe(25'h00003, 8'hA5);
      check("b0_we", 32'(prog_we), 32'd1);
      check("b0_ba", 32'(prog_ba), 32'd0);
      check("b0_addr", 32'(prog_addr), 32'd1);
      check("b0_data", 32'(prog_data), 32'hA5A5);
      check("b0_mask", 32'(prog_mask), 32'b01);
      tick(3);
      check("b0_hold_we", 32'(prog_we), 32'd1);
      check("b0_hold_addr", 32'(prog_addr), 32'd1);
      ack();
      check("b0_we_drop", 32'(prog_we), 32'd0);
      check("b0_busy", 32'(dwnld_busy), 32'd1);

      // Bank 1, even byte
      strobe(25'h20010, 8'h3C);
      check("b1_ba", 32'(prog_ba), 32'd1);
      check("b1_addr", 32'(prog_addr), 32'd8);
      check("b1_data", 32'(prog_data), 32'h3C3C);
      check("b1_mask", 32'(prog_mask), 32'b10);
      ack();

      // Bank 2 and bank 3
      strobe(25'h30005, 8'h11);
      check("b2_ba", 32'(prog_ba), 32'd2);
      check("b2_addr", 32'(prog_addr), 32'd2);
      check("b2_mask", 32'(prog_mask), 32'b01);
      ack();
      strobe(25'h130004, 8'h22);
      check("b3_ba", 32'(prog_ba), 32'd3);
      check("b3_addr", 32'(prog_addr), 32'd2);
      check("b3_mask", 32'(prog_mask), 32'b10);
      ack();

      // Strobe with downloading low is ignored
      downloading = 1'b0;
      strobe(25'h00010, 8'h99);
      check("nodl_we", 32'(prog_we), 32'd0);
      downloading = 1'b1;

      // Last PROM entry, then first address past the PROM
      strobe(25'h1400FF, 8'h9E);
      check("prom_we", 32'(prom_we), 32'd1);
      check("prom_addr", 32'(prom_addr), 32'hFF);
      check("prom_data", 32'(prom_data), 32'hE);
      check("prom_no_prog", 32'(prog_we), 32'd0);
      tick(1);
      check("prom_pulse_end", 32'(prom_we), 32'd0);
      strobe(25'h140100, 8'h55);
      check("drop_prom_we", 32'(prom_we), 32'd0);
      check("drop_prog_we", 32'(prog_we), 32'd0);
      check("drop_prom_addr", 32'(prom_addr), 32'hFF);

      // Ack and a new byte in the same cycle with empty buffer
      strobe(25'h00200, 8'h44);
      check("sim_first_addr", 32'(prog_addr), 32'h100);
      @(posedge clk); #1;
      prog_ack = 1'b1; ioctl_addr = 25'h00203; ioctl_dout = 8'h55; ioctl_wr = 1'b1;
      @(posedge clk); #1;
      prog_ack = 1'b0; ioctl_wr = 1'b0;
      check("sim_gap_we", 32'(prog_we), 32'd0);
      check("sim_ovf", 32'(ovf), 32'd0);
      tick(1);
      check("sim_we", 32'(prog_we), 32'd1);
      check("sim_addr", 32'(prog_addr), 32'h101);
      check("sim_data", 32'(prog_data), 32'h5555);
      check("sim_mask", 32'(prog_mask), 32'b01);
      ack();
      tick(1);
      check("sim_idle_we", 32'(prog_we), 32'd0);

      // Three strobes, late ack: one issued, one buffered, one lost
      strobe(25'h00100, 8'h01);
      strobe(25'h00102, 8'h02);
      check("ovf_pre", 32'(ovf), 32'd0);
      strobe(25'h00104, 8'h03);
      check("ovf_set", 32'(ovf), 32'd1);
      check("ovf_we1", 32'(prog_we), 32'd1);
      tick(4);
      check("ovf_hold_addr", 32'(prog_addr), 32'h80);
      check("ovf_hold_data", 32'(prog_data), 32'h0101);
      ack();
      check("ovf_gap_we", 32'(prog_we), 32'd0);
      check("ovf_buf_addr", 32'(prog_addr), 32'h81);
      check("ovf_buf_data", 32'(prog_data), 32'h0202);
      check("ovf_buf_mask", 32'(prog_mask), 32'b10);
      tick(1);
      check("ovf_we2", 32'(prog_we), 32'd1);
      ack();
      check("ovf_we2_drop", 32'(prog_we), 32'd0);
      tick(2);
      check("ovf_no_third", 32'(prog_we), 32'd0);
      check("ovf_last_addr", 32'(prog_addr), 32'h81);
      check("ovf_sticky", 32'(ovf), 32'd1);

      // Reset during a write
      strobe(25'h00040, 8'h66);
      check("rw_we", 32'(prog_we), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rw_we_clr", 32'(prog_we), 32'd0);
      check("rw_busy_clr", 32'(dwnld_busy), 32'd0);
      check("rw_ovf_clr", 32'(ovf), 32'd0);
      check("rw_mask", 32'(prog_mask), 32'd3);
      strobe(25'h00006, 8'h77);
      check("rw_new_we", 32'(prog_we), 32'd1);
      check("rw_new_addr", 32'(prog_addr), 32'd3);
      check("rw_new_data", 32'(prog_data), 32'h7777);
      check("rw_new_mask", 32'(prog_mask), 32'b10);
      ack();

      // Download ends with a write pending
      strobe(25'h00010, 8'h12);
      @(posedge clk); #1;
      downloading = 1'b0;
      tick(2);
      check("tail_busy", 32'(dwnld_busy), 32'd1);
      check("tail_we", 32'(prog_we), 32'd1);
      ack();
      check("tail_we_drop", 32'(prog_we), 32'd0);
      check("tail_busy_ack", 32'(dwnld_busy), 32'd1);
      tick(1);
      check("tail_busy_end", 32'(dwnld_busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/jtexterm_prom_we.md
JTEXTERM_PROM_WE -- requirements
Module: jtexterm_prom_we

Interface
REQ-001 Parameters: BA1_START, default 25'h20000, first ioctl byte of bank 1 (sub CPU ROM).
REQ-002 Parameters: BA2_START, default 25'h30000, first ioctl byte of bank 2 (GFX ROM).
REQ-003 Parameters: BA3_START, default 25'h130000, first ioctl byte of bank 3.
REQ-004 Parameters: PROM_START, default 25'h140000, first ioctl byte of the 256-entry colour PROM.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1: system clock; the single clock of the block.
- rst, in, 1: reset; synchronous, active-high.
- downloading, in, 1: ROM download in progress.
- ioctl_addr, in, 25: byte address of the incoming byte.
- ioctl_dout, in, 8: byte value.
- ioctl_wr, in, 1: one-cycle byte strobe.
- prog_addr, out, 22: SDRAM 16-bit word address.
- prog_data, out, 16: write data.
- prog_mask, out, 2: active-high lane mask; bit1 masks the upper byte, bit0 masks the lower byte.
- prog_ba, out, 2: SDRAM bank.
- prog_we, out, 1: write request.
- prog_rd, out, 1: read request; constant 0.
- prog_ack, in, 1: SDRAM accepted the request.
- prog_rdy, in, 1: SDRAM write complete; not used for sequencing.
- prom_we, out, 1: one-cycle PROM write pulse.
- prom_addr, out, 8: PROM address.
- prom_data, out, 4: PROM data.
- dwnld_busy, out, 1: download or write still pending.
- ovf, out, 1: sticky flag, set when a byte is lost.

Function
REQ-006 A byte is accepted only when ioctl_wr=1 and downloading=1; ioctl_wr=0 or downloading=0 is ignored.
REQ-007 Region decode, comparisons unsigned on the full 25-bit address; off = ioctl_addr minus the region start:
- below BA1_START: bank 0;
- below BA2_START: bank 1;
- below BA3_START: bank 2;
- below PROM_START: bank 3;
- below PROM_START+256: PROM;
- otherwise: the byte is dropped silently.
REQ-008 SDRAM byte: prog_addr = off[22:1], prog_ba = bank, prog_data = {ioctl_dout, ioctl_dout}.
REQ-009 prog_mask = 2'b10 when off[0]=0 (low byte written) and 2'b01 when off[0]=1.
REQ-010 PROM byte: prom_we pulses for exactly one cycle, the cycle after acceptance, with prom_addr = off[7:0] and prom_data = ioctl_dout[3:0]; no SDRAM request is issued.
REQ-011 FSM states IDLE and WRITE:
- IDLE -> WRITE on an accepted SDRAM byte; prog_we rises the following cycle.
- In WRITE, prog_we stays high and prog_addr/prog_data/prog_mask/prog_ba stay stable until prog_ack is sampled 1.
- On prog_ack in WRITE, prog_we drops the next cycle and the FSM returns to IDLE, or stays in WRITE loading the buffered entry.
REQ-012 One-entry buffer:
- An SDRAM byte accepted while in WRITE is stored in the buffer.
- If the buffer is already full, the byte is discarded and ovf sets; ovf stays set until rst.
REQ-013 When the buffer is loaded on prog_ack, prog_we goes low for exactly one cycle, then rises with the buffered request.
REQ-014 Simultaneous events: when prog_ack and a new accepted byte occur in the same cycle with the buffer empty, the new byte is issued as the next request (no loss, no ovf).
REQ-015 downloading falling mid-write does not abort: the pending write and any buffered write complete.
REQ-016 dwnld_busy = downloading OR state==WRITE OR buffer full, registered (one cycle of latency).
REQ-017 prog_rdy is ignored; completion of a write is defined by prog_ack alone.

Reset
REQ-018 On rst=1 at a clk edge the following clear to 0: the FSM (to IDLE), the buffer, prog_we, prom_we, ovf and dwnld_busy.
REQ-019 On the same edge, prog_addr, prog_data, prom_addr, prom_data and prog_ba clear to 0, and prog_mask goes to 2'b11.
REQ-020 An assertion of rst mid-write abandons the request with no handshake; the next accepted byte starts from IDLE.

Structure
REQ-021 Region start defaults and the bank encodings live in the shared package jtexterm_pkg.
REQ-022 One sub-module, jtexterm_dwn_dec, holds the combinational region decoder (address in; bank, offset, is_prom and drop out); the FSM and buffer stay in the top module.

Verification
REQ-023 Byte at ioctl_addr 0x00003 = 0xA5 -> prog_ba=0, prog_addr=1, prog_data=16'hA5A5, prog_mask=2'b01; prog_we held until prog_ack, then low.
REQ-024 Byte at ioctl_addr 0x20010 = 0x3C -> prog_ba=1, prog_addr=8, prog_mask=2'b10.
REQ-025 Byte at ioctl_addr 0x1400FF = 0x9E -> prom_we pulses once with prom_addr=0xFF, prom_data=4'hE, and prog_we stays 0; byte at 0x140100 -> no output at all.
REQ-026 Three strobes two cycles apart with prog_ack delayed 10 cycles:
- byte 1 is issued and byte 2 is buffered;
- byte 3 is discarded and ovf=1;
- exactly two prog_we high periods occur, separated by one low cycle.
REQ-027 rst asserted while prog_we=1 -> next cycle prog_we=0, dwnld_busy=0, ovf=0; a following byte is written normally.
REQ-028 downloading drops while a write is pending -> dwnld_busy stays 1 until prog_ack, then goes 0 one cycle later.
